// File: rtl/pll_lock_sequencer.sv
// Reset/lock sequencer for the rPLL that makes the 48 MHz USB clock from the 27 MHz oscillator.
// It qualifies LOCK, retries on timeout, faults once retries run out, and handles PSDA phase changes.
module pll_lock_sequencer #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 65535,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRIES   = 3,
  parameter int unsigned SETTLE_CYCLES = 256
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       pll_lock_i,
  output logic       pll_reset_o,
  output logic [3:0] pll_psda_o,
  input  logic       restart_i,
  input  logic       phase_req_i,
  input  logic [3:0] phase_val_i,
  output logic       phase_ack_o,
  output logic       ready_o,
  output logic       fault_o,
  output logic [1:0] retry_cnt_o,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    StPllRst   = 3'd0,
    StWaitLock = 3'd1,
    StStable   = 3'd2,
    StRun      = 3'd3,
    StSettle   = 3'd4,
    StFault    = 3'd5
  } state_e;

  localparam int unsigned MaxA = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned MaxB = (STABLE_CYCLES > SETTLE_CYCLES) ? STABLE_CYCLES : SETTLE_CYCLES;
  localparam int unsigned MaxT = (MaxA > MaxB) ? MaxA : MaxB;
  localparam int unsigned CntW = ($clog2(MaxT + 1) > 8) ? $clog2(MaxT + 1) : 8;

  localparam logic [CntW-1:0] RstLast     = CntW'(RST_CYCLES - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(LOCK_TIMEOUT - 1);
  localparam logic [CntW-1:0] StableLast  = CntW'(STABLE_CYCLES - 1);
  localparam logic [CntW-1:0] SettleLast  = CntW'(SETTLE_CYCLES - 1);
  localparam logic [7:0]      MaxRetries  = 8'(MAX_RETRIES);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  // Internal failure count is wider than the 2-bit debug output so MAX_RETRIES > 3 still works.
  logic [7:0]      fails_q, fails_d;
  logic [3:0]      psda_q, psda_d;
  logic            ack_q, ack_d;
  logic            lock_meta_q, lock_s_q;
  logic            fail;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
      state_q     <= StPllRst;
      cnt_q       <= '0;
      fails_q     <= '0;
      psda_q      <= 4'b0000;
      ack_q       <= 1'b0;
    end else begin
      lock_meta_q <= pll_lock_i;
      lock_s_q    <= lock_meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fails_q     <= fails_d;
      psda_q      <= psda_d;
      ack_q       <= ack_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    fails_d = fails_q;
    psda_d  = psda_q;
    ack_d   = 1'b0;
    fail    = 1'b0;

    unique case (state_q)
      StPllRst: begin
        if (cnt_q == RstLast) state_d = StWaitLock;
      end
      StWaitLock: begin
        if (lock_s_q) state_d = StStable;
        else if (cnt_q == TimeoutLast) fail = 1'b1;
      end
      StStable: begin
        if (!lock_s_q) state_d = StWaitLock;
        else if (cnt_q == StableLast) state_d = StRun;
      end
      StRun: begin
        if (!lock_s_q) begin
          fail = 1'b1;
        end else if (phase_req_i) begin
          psda_d  = phase_val_i;
          ack_d   = 1'b1;
          state_d = StSettle;
        end
      end
      StSettle: begin
        if (!lock_s_q) fail = 1'b1;
        else if (cnt_q == SettleLast) state_d = StRun;
      end
      StFault: ;
      default: state_d = StPllRst;
    endcase

    // Every failure (timeout or lock loss) draws from the same retry budget.
    if (fail) begin
      if (fails_q >= MaxRetries) begin
        state_d = StFault;
      end else begin
        fails_d = fails_q + 8'd1;
        state_d = StPllRst;
      end
    end

    // Restart overrides everything, including a pending phase request.
    if (restart_i) begin
      state_d = StPllRst;
      fails_d = '0;
      psda_d  = psda_q;
      ack_d   = 1'b0;
    end

    if ((state_d != state_q) || restart_i) cnt_d = '0;
  end

  assign pll_reset_o = (state_q == StPllRst) || (state_q == StFault);
  assign ready_o     = (state_q == StRun);
  assign fault_o     = (state_q == StFault);
  assign pll_psda_o  = psda_q;
  assign phase_ack_o = ack_q;
  assign retry_cnt_o = (fails_q > 8'd3) ? 2'd3 : fails_q[1:0];
  assign state_o     = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer: one instance with default timing, one with a short
// lock timeout for the retry/fault path.
module tb_pll_lock_sequencer;

  logic       clk, rst_n;
  logic       lock, restart, preq;
  logic [3:0] pval;
  logic       pll_reset, ack, ready, fault;
  logic [3:0] psda;
  logic [1:0] retry;
  logic [2:0] state;

  logic       f_lock, f_restart, f_preq;
  logic [3:0] f_pval;
  logic       f_reset, f_ack, f_ready, f_fault;
  logic [3:0] f_psda;
  logic [1:0] f_retry;
  logic [2:0] f_state;

  int total, bad;

  pll_lock_sequencer u_dut (
    .clk_i(clk), .rst_ni(rst_n), .pll_lock_i(lock), .pll_reset_o(pll_reset),
    .pll_psda_o(psda), .restart_i(restart), .phase_req_i(preq), .phase_val_i(pval),
    .phase_ack_o(ack), .ready_o(ready), .fault_o(fault), .retry_cnt_o(retry), .state_o(state)
  );

  pll_lock_sequencer #(.LOCK_TIMEOUT(100)) u_flt (
    .clk_i(clk), .rst_ni(rst_n), .pll_lock_i(f_lock), .pll_reset_o(f_reset),
    .pll_psda_o(f_psda), .restart_i(f_restart), .phase_req_i(f_preq), .phase_val_i(f_pval),
    .phase_ack_o(f_ack), .ready_o(f_ready), .fault_o(f_fault), .retry_cnt_o(f_retry),
    .state_o(f_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts rising edges (sampled 1 ns after each) until the selected signal equals lvl.
  // n = -1 when the bound expires.
  task automatic edges_until(input int sel, input logic lvl, input int limit, output int n);
    logic v;
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      @(posedge clk);
      #1;
      case (sel)
        0:       v = ready;
        1:       v = pll_reset;
        2:       v = ack;
        3:       v = (state == 3'd2);
        default: v = f_reset;
      endcase
      if (v === lvl) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; lock = 1'b0; restart = 1'b0; preq = 1'b0; pval = 4'h0;
    f_lock = 1'b0; f_restart = 1'b0; f_preq = 1'b0; f_pval = 4'h0;
    repeat (3) @(negedge clk);
    total++; if (pll_reset !== 1'b1) begin bad++; $display("FAIL reset_pll_reset got=%b want=1", pll_reset); end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", ready); end
    total++; if (fault !== 1'b0) begin bad++; $display("FAIL reset_fault got=%b want=0", fault); end
    total++; if (ack !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b want=0", ack); end
    total++; if (psda !== 4'h0) begin bad++; $display("FAIL reset_psda got=%h want=0", psda); end
    total++; if (retry !== 2'd0) begin bad++; $display("FAIL reset_retry got=%0d want=0", retry); end
    total++; if (state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", state); end
  endtask

  task automatic test_bringup;
    int n;
    @(negedge clk);
    rst_n = 1'b1;
    edges_until(1, 1'b0, 100, n);
    total++; if (n !== 16) begin bad++; $display("FAIL bringup_reset_width got=%0d want=16", n); end
    total++; if (state !== 3'd1) begin bad++; $display("FAIL bringup_wait_state got=%0d want=1", state); end
    repeat (99) @(posedge clk);
    @(negedge clk);
    lock = 1'b1;
    // Sampling edge, then 2 edges to STABLE entry, then 1024 stable cycles.
    edges_until(0, 1'b1, 1200, n);
    total++; if (n !== 1027) begin bad++; $display("FAIL bringup_ready_delay got=%0d want=1027", n); end
    total++; if (retry !== 2'd0) begin bad++; $display("FAIL bringup_retry got=%0d want=0", retry); end
    total++; if (pll_reset !== 1'b0) begin bad++; $display("FAIL bringup_pll_reset got=%b want=0", pll_reset); end
  endtask

  task automatic test_phase;
    int n;
    @(negedge clk);
    preq = 1'b1; pval = 4'hA;
    edges_until(2, 1'b1, 10, n);
    total++; if (n !== 1) begin bad++; $display("FAIL phase_ack_delay got=%0d want=1", n); end
    total++; if (psda !== 4'hA) begin bad++; $display("FAIL phase_psda got=%h want=a", psda); end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL phase_ready_low got=%b want=0", ready); end
    @(posedge clk);
    #1;
    total++; if (ack !== 1'b0) begin bad++; $display("FAIL phase_ack_single got=%b want=0", ack); end
    @(negedge clk);
    preq = 1'b0;
    // 256 settle cycles, one already elapsed above.
    edges_until(0, 1'b1, 400, n);
    total++; if (n !== 255) begin bad++; $display("FAIL phase_settle got=%0d want=255", n); end
    total++; if (psda !== 4'hA) begin bad++; $display("FAIL phase_psda_hold got=%h want=a", psda); end
  endtask

  task automatic test_lock_loss;
    int n;
    @(negedge clk);
    lock = 1'b0;
    edges_until(0, 1'b0, 20, n);
    total++; if (n !== 3) begin bad++; $display("FAIL loss_ready_fall got=%0d want=3", n); end
    total++; if (pll_reset !== 1'b1) begin bad++; $display("FAIL loss_pll_reset got=%b want=1", pll_reset); end
    total++; if (retry !== 2'd1) begin bad++; $display("FAIL loss_retry got=%0d want=1", retry); end
    edges_until(1, 1'b0, 50, n);
    total++; if (n !== 16) begin bad++; $display("FAIL loss_reset_width got=%0d want=16", n); end
    @(negedge clk);
    lock = 1'b1;
    edges_until(0, 1'b1, 1200, n);
    total++; if (n !== 1027) begin bad++; $display("FAIL loss_relock got=%0d want=1027", n); end
    total++; if (retry !== 2'd1) begin bad++; $display("FAIL loss_retry_keep got=%0d want=1", retry); end
  endtask

  task automatic test_back_to_back;
    int n;
    @(negedge clk);
    restart = 1'b1; preq = 1'b1; pval = 4'h5;
    @(negedge clk);
    restart = 1'b0;
    total++; if (ack !== 1'b0) begin bad++; $display("FAIL b2b_no_ack got=%b want=0", ack); end
    total++; if (state !== 3'd0) begin bad++; $display("FAIL b2b_state got=%0d want=0", state); end
    total++; if (retry !== 2'd0) begin bad++; $display("FAIL b2b_retry_clear got=%0d want=0", retry); end
    total++; if (psda !== 4'hA) begin bad++; $display("FAIL b2b_psda_keep got=%h want=a", psda); end
    // 16 reset + 1 wait + 1024 stable + 1 RUN cycle before the ack.
    edges_until(2, 1'b1, 1200, n);
    total++; if (n !== 1042) begin bad++; $display("FAIL b2b_late_ack got=%0d want=1042", n); end
    total++; if (psda !== 4'h5) begin bad++; $display("FAIL b2b_psda got=%h want=5", psda); end
    @(negedge clk);
    preq = 1'b0;
  endtask

  task automatic test_glitch;
    int n;
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    edges_until(3, 1'b1, 50, n);
    total++; if (n !== 17) begin bad++; $display("FAIL glitch_stable_entry got=%0d want=17", n); end
    repeat (500) @(posedge clk);
    @(negedge clk);
    lock = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (state !== 3'd1) begin bad++; $display("FAIL glitch_back_to_wait got=%0d want=1", state); end
    lock = 1'b1;
    edges_until(0, 1'b1, 1200, n);
    total++; if (n !== 1027) begin bad++; $display("FAIL glitch_ready_delay got=%0d want=1027", n); end
    total++; if (retry !== 2'd0) begin bad++; $display("FAIL glitch_retry got=%0d want=0", retry); end
  endtask

  task automatic test_fault;
    int n;
    @(negedge clk);
    f_restart = 1'b1;
    @(negedge clk);
    f_restart = 1'b0;
    for (int k = 0; k < 4; k++) begin
      edges_until(4, 1'b0, 50, n);
      total++; if (n !== 16) begin bad++; $display("FAIL fault_pulse%0d got=%0d want=16", k, n); end
      total++; if (f_retry !== 2'(k)) begin bad++; $display("FAIL fault_retry%0d got=%0d want=%0d", k, f_retry, k); end
      edges_until(4, 1'b1, 200, n);
      total++; if (n !== 100) begin bad++; $display("FAIL fault_timeout%0d got=%0d want=100", k, n); end
      if (k < 3) begin
        total++; if (f_retry !== 2'(k + 1)) begin bad++; $display("FAIL fault_step%0d got=%0d want=%0d", k, f_retry, k + 1); end
        total++; if (f_fault !== 1'b0) begin bad++; $display("FAIL fault_early%0d got=%b want=0", k, f_fault); end
      end else begin
        total++; if (f_fault !== 1'b1) begin bad++; $display("FAIL fault_set got=%b want=1", f_fault); end
        total++; if (f_state !== 3'd5) begin bad++; $display("FAIL fault_state got=%0d want=5", f_state); end
      end
    end
    repeat (200) @(posedge clk);
    @(negedge clk);
    total++; if (f_reset !== 1'b1) begin bad++; $display("FAIL fault_reset_held got=%b want=1", f_reset); end
    total++; if (f_retry !== 2'd3) begin bad++; $display("FAIL fault_retry_sat got=%0d want=3", f_retry); end
    f_restart = 1'b1;
    @(negedge clk);
    f_restart = 1'b0;
    total++; if (f_fault !== 1'b0) begin bad++; $display("FAIL fault_cleared got=%b want=0", f_fault); end
    total++; if (f_retry !== 2'd0) begin bad++; $display("FAIL fault_retry_clear got=%0d want=0", f_retry); end
    total++; if (f_state !== 3'd0) begin bad++; $display("FAIL fault_restart_state got=%0d want=0", f_state); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_bringup();
    test_phase();
    test_lock_loss();
    test_back_to_back();
    test_glitch();
    test_fault();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
